// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundles the decode-side issue information, the register-file and stage
//   result buses, and the bypass/stall outputs of hazard_scoreboard.
//   master : decode/execute pipeline side (drives issue info and data buses)
//   slave  : the scoreboard (drives op1/op2, fwd_sel1/fwd_sel2, stall)
//   SELW = $clog2(DEPTH+1); fwd_sel 0 = register file, k+1 = stage k.
interface hazard_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 3
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                    issue_valid;
    logic [4:0]              issue_rs1;
    logic [4:0]              issue_rs2;
    logic                    issue_use1;
    logic                    issue_use2;
    logic [4:0]              issue_rd;
    logic                    issue_wb;
    logic                    issue_load;
    logic                    flush;
    logic [XLEN-1:0]         rf_data1;
    logic [XLEN-1:0]         rf_data2;
    logic [DEPTH*XLEN-1:0]   stage_data;
    logic [XLEN-1:0]         op1;
    logic [XLEN-1:0]         op2;
    logic [SELW-1:0]         fwd_sel1;
    logic [SELW-1:0]         fwd_sel2;
    logic                    stall;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
               issue_rd, issue_wb, issue_load, flush,
               rf_data1, rf_data2, stage_data,
        input  op1, op2, fwd_sel1, fwd_sel2, stall
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
               issue_rd, issue_wb, issue_load, flush,
               rf_data1, rf_data2, stage_data,
        output op1, op2, fwd_sel1, fwd_sel2, stall
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks destination tags of the DEPTH instructions past decode, selects
//   each ID source operand from the register file or the youngest matching
//   stage, and raises a load-use stall when the value is not yet available.
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high, clears all state
//   bus        : hazard_scoreboard_if.slave (issue info, rf/stage data in,
//                op1/op2, fwd_sel1/fwd_sel2, stall out)
//   stall_count, fwd_count : 32-bit saturating statistics, present only when
//                the HAZARD_STATS_EN macro is defined
// Parameters: XLEN (datapath width), DEPTH (1..8 tracked stages, 0 = EX),
//   LOAD_READY (0..DEPTH-1, first stage whose stage_data holds load results).
module hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1
) (
    input  logic                clock,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_count,
    output logic [31:0]         fwd_count
`endif
);
    localparam int SELW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       load;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q;
    entry_t [DEPTH-1:0] ent_d;

    logic [SELW-1:0] sel1;
    logic [SELW-1:0] sel2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            lu1;
    logic            lu2;
    logic            stall;

    // Operand selection. Walking from the oldest stage to the youngest lets
    // the youngest match overwrite older ones. Matches are suppressed while
    // reset is high so fwd_sel and stall drop in the same cycle.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        op1  = bus.rf_data1;
        op2  = bus.rf_data2;
        lu1  = 1'b0;
        lu2  = 1'b0;
        for (int unsigned k = DEPTH; k > 0; k--) begin
            if (!reset && bus.issue_use1 && ent_q[k-1].v &&
                bus.issue_rs1 != 5'd0 && ent_q[k-1].rd == bus.issue_rs1) begin
                sel1 = SELW'(k);
                op1  = bus.stage_data[(k-1)*XLEN +: XLEN];
                lu1  = ent_q[k-1].load && ((k - 1) < unsigned'(LOAD_READY));
            end
            if (!reset && bus.issue_use2 && ent_q[k-1].v &&
                bus.issue_rs2 != 5'd0 && ent_q[k-1].rd == bus.issue_rs2) begin
                sel2 = SELW'(k);
                op2  = bus.stage_data[(k-1)*XLEN +: XLEN];
                lu2  = ent_q[k-1].load && ((k - 1) < unsigned'(LOAD_READY));
            end
        end
        stall = bus.issue_valid && !bus.flush && (lu1 || lu2);
    end

    always_comb begin
        bus.op1      = op1;
        bus.op2      = op2;
        bus.fwd_sel1 = sel1;
        bus.fwd_sel2 = sel2;
        bus.stall    = stall;
    end

    // Entry shift: stages never stall. wb and rd!=0 are folded into v, and a
    // stalled or flushed ID instruction enters as a bubble.
    always_comb begin
        ent_d = ent_q;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
        ent_d[0].v    = bus.issue_valid && bus.issue_wb && bus.issue_rd != 5'd0 &&
                        !stall && !bus.flush;
        ent_d[0].rd   = bus.issue_rd;
        ent_d[0].load = bus.issue_load;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q;
    logic [31:0] fwd_count_q;
    logic        fwd_event;

    always_comb begin
        fwd_event = bus.issue_valid && !stall && !bus.flush &&
                    (sel1 != '0 || sel2 != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            if (stall && stall_count_q != '1) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (fwd_event && fwd_count_q != '1) begin
                fwd_count_q <= fwd_count_q + 32'd1;
            end
        end
    end

    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    localparam int XLEN       = 32;
    localparam int DEPTH      = 3;
    localparam int LOAD_READY = 1;
    localparam int SELW       = $clog2(DEPTH + 1);

    logic clock;
    logic reset;
    int   vecs;
    int   miscompares;

    hazard_scoreboard_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] fwd_count;
    logic [31:0] exp_sc;
    logic [31:0] exp_fc;
`endif

    hazard_scoreboard #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .LOAD_READY(LOAD_READY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count(stall_count),
        .fwd_count(fwd_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: list of in-flight register writers with their age in
    // cycles since leaving ID (age 0 = EX). An instruction older than DEPTH-1
    // is retired.
    typedef struct {
        int         age;
        logic [4:0] rd;
        bit         load;
    } inflight_t;

    inflight_t inflight[$];

    function automatic void predict(input logic [4:0] rs, input logic use_s,
                                    input logic [XLEN-1:0] rf,
                                    output logic [SELW-1:0] sel,
                                    output logic [XLEN-1:0] op, output bit lu);
        int best;
        bit bload;
        best  = DEPTH;
        bload = 0;
        if (!reset && use_s && rs != 5'd0) begin
            foreach (inflight[i]) begin
                if (inflight[i].rd == rs && inflight[i].age < best) begin
                    best  = inflight[i].age;
                    bload = inflight[i].load;
                end
            end
        end
        if (best < DEPTH) begin
            sel = SELW'(best + 1);
            op  = bus.stage_data[best*XLEN +: XLEN];
            lu  = bload && (best < LOAD_READY);
        end else begin
            sel = '0;
            op  = rf;
            lu  = 0;
        end
    endfunction

    function automatic bit exp_stall();
        logic [SELW-1:0] s;
        logic [XLEN-1:0] o;
        bit l1, l2;
        predict(bus.issue_rs1, bus.issue_use1, bus.rf_data1, s, o, l1);
        predict(bus.issue_rs2, bus.issue_use2, bus.rf_data2, s, o, l2);
        return bus.issue_valid && !bus.flush && (l1 || l2);
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wb, input logic ld,
                         input logic fl);
        bus.issue_valid = v;
        bus.issue_rs1   = rs1;
        bus.issue_use1  = u1;
        bus.issue_rs2   = rs2;
        bus.issue_use2  = u2;
        bus.issue_rd    = rd;
        bus.issue_wb    = wb;
        bus.issue_load  = ld;
        bus.flush       = fl;
        bus.rf_data1    = $urandom;
        bus.rf_data2    = $urandom;
        for (int i = 0; i < DEPTH; i++) bus.stage_data[i*XLEN +: XLEN] = $urandom;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic tick();
        logic [SELW-1:0] s1, s2;
        logic [XLEN-1:0] o1, o2;
        bit l1, l2, st, acc;
        predict(bus.issue_rs1, bus.issue_use1, bus.rf_data1, s1, o1, l1);
        predict(bus.issue_rs2, bus.issue_use2, bus.rf_data2, s2, o2, l2);
        st  = bus.issue_valid && !bus.flush && (l1 || l2);
        acc = bus.issue_valid && bus.issue_wb && bus.issue_rd != 5'd0 && !st && !bus.flush;
`ifdef HAZARD_STATS_EN
        if (reset) begin
            exp_sc = '0;
            exp_fc = '0;
        end else begin
            if (st && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 1;
            if (bus.issue_valid && !st && !bus.flush && (s1 != 0 || s2 != 0) &&
                exp_fc != 32'hFFFF_FFFF) exp_fc = exp_fc + 1;
        end
`endif
        @(posedge clock);
        #1;
        if (reset) begin
            inflight.delete();
        end else begin
            foreach (inflight[i]) inflight[i].age++;
            for (int i = inflight.size() - 1; i >= 0; i--)
                if (inflight[i].age >= DEPTH) inflight.delete(i);
            if (acc) inflight.push_back('{0, bus.issue_rd, bus.issue_load});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 5'd5, 1, 1, 0);   // lw x5
        tick();
        // Dependent on the load while reset is held: no stall, no forward.
        reset = 1'b1;
        drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
        vecs++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held_stall: got %0b want 0", bus.stall);
        end
        vecs++;
        if (bus.fwd_sel1 !== '0) begin
            miscompares++;
            $display("FAIL reset_held_sel1: got %0d want 0", bus.fwd_sel1);
        end
        tick();
        reset = 1'b0;
        drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        vecs++;
        if (bus.stall !== 1'b0 || bus.fwd_sel1 !== '0 || bus.fwd_sel2 !== '0) begin
            miscompares++;
            $display("FAIL reset_after: stall %0b sel1 %0d sel2 %0d want 0 0 0",
                     bus.stall, bus.fwd_sel1, bus.fwd_sel2);
        end
        vecs++;
        if (bus.op1 !== bus.rf_data1) begin
            miscompares++;
            $display("FAIL reset_after_op1: got %h want %h", bus.op1, bus.rf_data1);
        end
        tick();
    endtask

    task automatic test_alu_chain();
        drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);   // addi x5
        tick();
        drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);  // add x6,x5,x5
        vecs++;
        if (bus.fwd_sel1 !== SELW'(1) || bus.fwd_sel2 !== SELW'(1)) begin
            miscompares++;
            $display("FAIL alu_sel: got %0d/%0d want 1/1", bus.fwd_sel1, bus.fwd_sel2);
        end
        vecs++;
        if (bus.op1 !== bus.stage_data[XLEN-1:0] || bus.op2 !== bus.stage_data[XLEN-1:0]) begin
            miscompares++;
            $display("FAIL alu_op: got %h/%h want %h", bus.op1, bus.op2, bus.stage_data[XLEN-1:0]);
        end
        vecs++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_stall: got %0b want 0", bus.stall);
        end
        tick();
    endtask

    task automatic test_load_use();
        int stall_cycles;
        drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0);   // lw x7
        tick();
        stall_cycles = 0;
        drive(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0);  // add x8,x7,x0
        while (bus.stall === 1'b1 && stall_cycles < 5) begin
            stall_cycles++;
            tick();
            drive(1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0);
        end
        vecs++;
        if (stall_cycles != 1) begin
            miscompares++;
            $display("FAIL load_use_len: got %0d stall cycles want 1", stall_cycles);
        end
        vecs++;
        if (bus.fwd_sel1 !== SELW'(2) || bus.op1 !== bus.stage_data[XLEN +: XLEN]) begin
            miscompares++;
            $display("FAIL load_use_fwd: sel %0d op %h want 2 %h",
                     bus.fwd_sel1, bus.op1, bus.stage_data[XLEN +: XLEN]);
        end
        tick();
    endtask

    task automatic test_priority();
        drive(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 5'd3, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);
        tick();
        drive(1, 5'd9, 1, 5'd0, 0, 5'd1, 0, 0, 0);
        bus.stage_data[0 +: XLEN]      = 32'h11;
        bus.stage_data[XLEN +: XLEN]   = 32'h22;
        bus.stage_data[2*XLEN +: XLEN] = 32'h33;
        #1;
        vecs++;
        if (bus.op1 !== 32'h11 || bus.fwd_sel1 !== SELW'(1)) begin
            miscompares++;
            $display("FAIL priority: op %h sel %0d want 11 1", bus.op1, bus.fwd_sel1);
        end
        tick();
    endtask

    task automatic test_x0_unused();
        drive(1, 0, 0, 0, 0, 5'd0, 1, 0, 0);   // writes x0
        tick();
        drive(1, 5'd0, 1, 5'd0, 0, 5'd1, 0, 0, 0);
        bus.rf_data1 = '0;
        #1;
        vecs++;
        if (bus.fwd_sel1 !== '0 || bus.op1 !== '0) begin
            miscompares++;
            $display("FAIL x0: sel %0d op %h want 0 0", bus.fwd_sel1, bus.op1);
        end
        tick();
        drive(1, 0, 0, 0, 0, 5'd10, 1, 1, 0);  // lw x10
        tick();
        drive(1, 5'd0, 0, 5'd10, 0, 5'd1, 1, 0, 0);
        vecs++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL unused_src_stall: got %0b want 0", bus.stall);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 0, 0, 5'd11, 1, 1, 0);  // lw x11
        tick();
        drive(1, 5'd11, 1, 5'd0, 0, 5'd12, 1, 0, 1);  // dependent, flushed
        vecs++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stall: got %0b want 0", bus.stall);
        end
        tick();
        drive(1, 5'd12, 1, 5'd11, 1, 5'd1, 0, 0, 0);
        vecs++;
        if (bus.fwd_sel1 !== '0) begin
            miscompares++;
            $display("FAIL flush_bubble: sel1 %0d want 0", bus.fwd_sel1);
        end
        vecs++;
        if (bus.fwd_sel2 !== SELW'(2) || bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_older: sel2 %0d stall %0b want 2 0", bus.fwd_sel2, bus.stall);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 0, 0, 0, 0, 5'd13, 1, 1, 0);
        tick();
        drive(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, 0, 0);
        vecs++;
        if (bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_stall_pre: got %0b want 1", bus.stall);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_stall_reset: got %0b want 0", bus.stall);
        end
        tick();
        reset = 1'b0;
        drive(1, 5'd13, 1, 5'd13, 1, 5'd1, 0, 0, 0);
        vecs++;
        if (bus.stall !== 1'b0 || bus.fwd_sel1 !== '0) begin
            miscompares++;
            $display("FAIL mid_stall_after: stall %0b sel %0d want 0 0", bus.stall, bus.fwd_sel1);
        end
        tick();
    endtask

    task automatic test_random();
        logic [SELW-1:0] s1, s2;
        logic [XLEN-1:0] o1, o2;
        bit l1, l2, st;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0);
            predict(bus.issue_rs1, bus.issue_use1, bus.rf_data1, s1, o1, l1);
            predict(bus.issue_rs2, bus.issue_use2, bus.rf_data2, s2, o2, l2);
            st = exp_stall();
            vecs++;
            if (bus.fwd_sel1 !== s1 || bus.op1 !== o1) begin
                miscompares++;
                $display("FAIL rand_src1 @%0d: sel %0d op %h want %0d %h", n, bus.fwd_sel1, bus.op1, s1, o1);
            end
            vecs++;
            if (bus.fwd_sel2 !== s2 || bus.op2 !== o2) begin
                miscompares++;
                $display("FAIL rand_src2 @%0d: sel %0d op %h want %0d %h", n, bus.fwd_sel2, bus.op2, s2, o2);
            end
            vecs++;
            if (bus.stall !== st) begin
                miscompares++;
                $display("FAIL rand_stall @%0d: got %0b want %0b", n, bus.stall, st);
            end
            tick();
        end
        reset = 1'b0;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        vecs++;
        if (stall_count !== exp_sc || fwd_count !== exp_fc) begin
            miscompares++;
            $display("FAIL stats_count: got %0d/%0d want %0d/%0d", stall_count, fwd_count, exp_sc, exp_fc);
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        vecs++;
        if (stall_count !== 32'd0 || fwd_count !== 32'd0) begin
            miscompares++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0", stall_count, fwd_count);
        end
    endtask
`endif

    initial begin
        vecs        = 0;
        miscompares = 0;
        reset       = 1'b1;
`ifdef HAZARD_STATS_EN
        exp_sc = '0;
        exp_fc = '0;
`endif
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_priority();
        test_x0_unused();
        test_flush();
        test_reset_mid_stall();
        test_random();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and operand-bypass unit for the in-order RISC-V pipeline. It sits between decode and execute. It tracks the destination tags of every in-flight instruction across DEPTH post-decode stages. It selects each ID-stage source operand from the register file or from the youngest matching stage, and raises a load-use stall when a needed value is not yet produced. It generalises the fixed EX/ME forwarding to any pipeline depth and load latency, and adds bubble insertion and optional statistics.

## Interface
Parameters:
- XLEN, 32, datapath width
- DEPTH, 3, tracked stages after ID (index 0 = EX, 1 = ME, 2 = WB, ...); legal range 1..8
- LOAD_READY, 1, first stage index whose stage_data carries load results; legal range 0..DEPTH-1

Ports (SELW = $clog2(DEPTH+1)):
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- issue_valid  in  1  ID holds a valid instruction
- issue_rs1, issue_rs2  in  5  source register indices
- issue_use1, issue_use2  in  1  source is actually read by the instruction
- issue_rd  in  5  destination index
- issue_wb  in  1  instruction writes rd
- issue_load  in  1  instruction is a load
- flush  in  1  branch/jump taken in EX; squash the ID instruction
- rf_data1, rf_data2  in  XLEN  register-file read data
- stage_data  in  DEPTH*XLEN  result of stage k at bits [k*XLEN +: XLEN]
- op1, op2  out  XLEN  bypassed operands to ID/EX
- fwd_sel1, fwd_sel2  out  SELW  0 = register file, k+1 = stage k
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- stall_count, fwd_count  out  32  present only with HAZARD_STATS_EN

## Operation
- State: DEPTH entries {v, rd, load}. Entry k describes the instruction currently in stage k.
- Match k for source s: use_s & v[k] & wb[k] & rd[k]==rs_s & rs_s!=0. The wb bit is folded into v: entries with wb=0 or rd=0 are stored with v=0.
- Selection: the youngest match (smallest k) wins. fwd_sel = k+1 and op = stage_data[k]. With no match: fwd_sel = 0 and op = rf_data.
- Load-use: the winning entry has load=1 and k < LOAD_READY. stall = issue_valid & !flush & (load-use on src1 | load-use on src2).
- Update each edge:
  - entry[k+1] <= entry[k] for k = 0..DEPTH-2; the oldest entry is retired.
  - entry[0] <= {issue_valid & issue_wb & issue_rd!=0 & !stall & !flush, issue_rd, issue_load}.
- Stall inserts a bubble in entry[0]. Older entries keep shifting, so the stall self-clears after LOAD_READY-k cycles.
- flush takes precedence over stall: the ID instruction is dropped, stall = 0, and entry[0] becomes a bubble.
- rs = x0 is never forwarded and never stalls. op is then rf_data, which is 0.
- Sources with use = 0 never stall. op/fwd_sel are still driven per the selection rule.

## Timing
- op, fwd_sel and stall are purely combinational from the inputs and the current entries; zero cycles latency.
- Entry shift: one cycle per stage, unconditional; the tracked stages never stall.
- Reset: all v = 0 on the edge where reset = 1. While reset is asserted, or in the cycle after it, stall = 0 and fwd_sel = 0.
- Reset mid-stall: entries clear on that edge, and the stall drops immediately.
- Back-to-back writers of the same rd: the younger one is forwarded.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count and fwd_count ports exist.
  - stall_count increments each cycle with stall = 1.
  - fwd_count increments each cycle with issue_valid & !stall & !flush & (fwd_sel1!=0 | fwd_sel2!=0).
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent, and functional behaviour is identical.

## Test plan
- ALU chain, DEPTH=3: addi x5 issued, next cycle add x6,x5,x5 -> fwd_sel1 = fwd_sel2 = 1, op1 = stage_data[0]. No stall.
- Load-use, LOAD_READY=1: lw x7 issued, then add x8,x7,x0 -> stall = 1 for exactly 1 cycle. Next cycle fwd_sel1 = 2, op1 = stage_data[1].
- Priority: writers of x9 in stage 0 and stage 2 (stage_data 0x11, 0x33) -> op1 = 0x11, fwd_sel1 = 1.
- x0 and unused: rs1 = x0 while an entry has rd = x0 wb = 1 -> fwd_sel1 = 0, op1 = 0. Load-use on a use2 = 0 source -> stall = 0.
- Flush vs stall: load-use condition with flush = 1 -> stall = 0. The next-cycle entry[0] is invalid.
- Stats (HAZARD_STATS_EN): 3 stall cycles and 5 forwards -> stall_count = 3, fwd_count = 5. Reset -> both 0. Preloaded saturation holds at 0xFFFF_FFFF.
